// File: rtl/spine_port_arbiter_pkg.sv
// Shared types and defaults for the spine router's round-robin port arbiter.
package spine_arb_pkg;

  localparam int NUM_PORTS_DEF = 11;
  localparam int IDX_W_DEF     = 4;
  localparam int TIMEOUT_DEF   = 64;
  localparam int TO_W_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/spine_port_arbiter_if.sv
// Handshake bundle between the input ports, the arbiter (master) and the forwarding engine (slave).
interface spine_port_arbiter_if #(
  parameter int NUM_PORTS = spine_arb_pkg::NUM_PORTS_DEF,
  parameter int IDX_W     = spine_arb_pkg::IDX_W_DEF
);
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic                 grant_ack;
  logic                 xfer_done;
  logic                 timeout_err;
  logic [15:0]          stat_grants;

  modport master (
    input  req, grant_ack, xfer_done,
    output grant, grant_idx, grant_valid, timeout_err, stat_grants
  );

  modport slave (
    output req, grant_ack, xfer_done,
    input  grant, grant_idx, grant_valid, timeout_err, stat_grants
  );
endinterface

// File: rtl/spine_port_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first set request at or after rr_ptr, wrapping.
module spine_rr_pick
  import spine_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] winner,
  output logic [IDX_W-1:0]     winner_idx,
  output logic                 found
);

  logic [IDX_W:0]   pos_sum;
  logic [IDX_W-1:0] pos;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path can infer a latch.
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    pos_sum    = '0;
    pos        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pos_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (pos_sum >= (IDX_W+1)'(NUM_PORTS))
        pos_sum = pos_sum - (IDX_W+1)'(NUM_PORTS);
      pos = pos_sum[IDX_W-1:0];
      if (!found && req[pos]) begin
        found       = 1'b1;
        winner[pos] = 1'b1;
        winner_idx  = pos + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/spine_port_arbiter.sv
// Round-robin arbiter sharing the forwarding engine: offer/accept/complete handshake plus stall watchdog.
// Optional completed-grant counter enabled by defining SPINE_ARB_STATS_EN.
module spine_port_arbiter
  import spine_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int TO_W      = TO_W_DEF
) (
  input logic clk,
  input logic reset,
  spine_port_arbiter_if.master bus
);

  localparam logic [TO_W-1:0]  WD_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS);

  arb_state_e           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [TO_W-1:0]      wd_cnt;
  logic [NUM_PORTS-1:0] pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;

  spine_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req        (bus.req),
    .rr_ptr     (rr_ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .found      (pick_found)
  );

  // NOTE: all state and outputs are non-blocking so every read sees last cycle's value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      wd_cnt          <= '0;
      bus.grant       <= '0;
      bus.grant_idx   <= '0;
      bus.grant_valid <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            bus.grant       <= pick_onehot;
            bus.grant_idx   <= pick_idx;
            bus.grant_valid <= 1'b1;
            state           <= OFFER;
          end
        end
        OFFER: begin
          // Acceptance beats a simultaneous request drop.
          if (bus.grant_ack) begin
            state  <= BUSY;
            rr_ptr <= (bus.grant_idx == LAST_IDX) ? '0 : bus.grant_idx;
            wd_cnt <= '0;
          end else if ((bus.req & bus.grant) == '0) begin
            bus.grant       <= '0;
            bus.grant_idx   <= '0;
            bus.grant_valid <= 1'b0;
            state           <= IDLE;
          end
        end
        BUSY: begin
          if (bus.xfer_done) begin
            bus.grant       <= '0;
            bus.grant_idx   <= '0;
            bus.grant_valid <= 1'b0;
            state           <= IDLE;
          end else if (wd_cnt == WD_LAST) begin
            bus.timeout_err <= 1'b1;
            bus.grant       <= '0;
            bus.grant_idx   <= '0;
            bus.grant_valid <= 1'b0;
            state           <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + TO_W'(1);
          end
        end
        default: begin
          bus.grant       <= '0;
          bus.grant_idx   <= '0;
          bus.grant_valid <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

`ifdef SPINE_ARB_STATS_EN
  // Counts completions only; a watchdog abort is not a completed grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bus.stat_grants <= '0;
    else if (state == BUSY && bus.xfer_done && bus.stat_grants != 16'hFFFF)
      bus.stat_grants <= bus.stat_grants + 16'd1;
  end
`else
  assign bus.stat_grants = '0;
`endif

endmodule
